// File: rtl/simd_add_pkg.sv
// Shared widths and the result-group record for the scalar-to-SIMD add gatherer.
package simd_add_pkg;
  localparam int LANE_W    = 12;
  localparam int LANES     = 4;
  localparam int GRP_DEPTH = 3;

  typedef struct packed {
    logic [LANES-1:0]             mask;
    logic [LANES-1:0][LANE_W-1:0] sum;
  } grp_t;
endpackage

// File: rtl/simd_add4.sv
// Four-lane 12-bit SIMD adder with one output register stage, gated by ce.
module simd_add4
  import simd_add_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ce,
  input  logic [LANE_W-1:0] a0_val, a1_val, a2_val, a3_val,
  input  logic [LANE_W-1:0] b0_val, b1_val, b2_val, b3_val,
  output logic [LANE_W-1:0] ap_return_0, ap_return_1, ap_return_2, ap_return_3
);
  logic [LANE_W-1:0] a [LANES];
  logic [LANE_W-1:0] b [LANES];
  logic [LANE_W-1:0] s_reg [LANES];

  assign a[0] = a0_val;  assign a[1] = a1_val;  assign a[2] = a2_val;  assign a[3] = a3_val;
  assign b[0] = b0_val;  assign b[1] = b1_val;  assign b[2] = b2_val;  assign b[3] = b3_val;
  assign ap_return_0 = s_reg[0];
  assign ap_return_1 = s_reg[1];
  assign ap_return_2 = s_reg[2];
  assign ap_return_3 = s_reg[3];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < LANES; i++) s_reg[i] <= '0;
    end else if (ce) begin
      for (int i = 0; i < LANES; i++) s_reg[i] <= a[i] + b[i];
    end
  end
endmodule

// File: rtl/simd_grp_fifo.sv
// Small show-ahead FIFO of completed SIMD groups; head is valid whenever not empty.
module simd_grp_fifo
  import simd_add_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic push,
  input  grp_t push_grp,
  input  logic pop,
  output grp_t head_grp,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(GRP_DEPTH);

  grp_t          mem [GRP_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   cnt_reg;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(GRP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (cnt_reg == (PW+1)'(GRP_DEPTH));
  assign empty    = (cnt_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_grp = mem[rd_ptr_reg];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      for (int i = 0; i < GRP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= push_grp;
        wr_ptr_reg      <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      cnt_reg <= cnt_reg + 1'b1;
      else if (!do_push && do_pop) cnt_reg <= cnt_reg - 1'b1;
    end
  end
endmodule

// File: rtl/simd_add4_gather.sv
// Gathers scalar 12-bit add requests into four-lane groups for an external SIMD adder
// and replays the lane sums one per handshake in arrival order.
module simd_add4_gather
  import simd_add_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_a,
  input  logic [LANE_W-1:0] in_b,
  input  logic              flush,
  output logic [LANE_W-1:0] a0_val, a1_val, a2_val, a3_val,
  output logic [LANE_W-1:0] b0_val, b1_val, b2_val, b3_val,
  output logic              simd_ce,
  input  logic [LANE_W-1:0] ap_return_0, ap_return_1, ap_return_2, ap_return_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_sum,
  output logic              busy
);
  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

  logic [2:0]        count_reg;
  logic [7:0]        timer_reg;
  logic [1:0]        credit_reg;
  logic [LANE_W-1:0] lane_a_reg [LANES];
  logic [LANE_W-1:0] lane_b_reg [LANES];
  logic [LANE_W-1:0] a_val_reg [LANES];
  logic [LANE_W-1:0] b_val_reg [LANES];
  logic [LANES-1:0]  fl1_mask_reg, fl2_mask_reg, done_reg;
  logic              fl1_vld_reg, fl2_vld_reg;

  logic             issue, accept, handshake, pop, fifo_full, fifo_empty;
  logic [LANES-1:0] gather_mask, remaining, cur_onehot;
  logic [1:0]       wr_idx, cur_idx;
  grp_t             push_grp, head_grp;

  // Credit covers adder pipeline plus FIFO, so the FIFO can never overflow.
  assign issue = (credit_reg < 2'd3) && !fifo_full &&
                 ((count_reg == 3'd4) ||
                  ((count_reg != 3'd0) && (flush || (timer_reg == TIMER_MAX))));
  assign in_ready = !ap_rst && ((count_reg < 3'd4) || issue);
  assign accept   = in_valid && in_ready;
  assign wr_idx   = issue ? 2'd0 : count_reg[1:0];
  assign simd_ce  = !ap_rst;
  assign busy     = (count_reg != 3'd0) || (credit_reg != 2'd0);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign gather_mask[gi]  = (count_reg > 3'(gi));
      assign push_grp.sum[gi] = (gi == 0) ? ap_return_0 : (gi == 1) ? ap_return_1 :
                                (gi == 2) ? ap_return_2 : ap_return_3;
    end
  endgenerate

  assign push_grp.mask = fl2_mask_reg;
  assign a0_val = a_val_reg[0];  assign a1_val = a_val_reg[1];
  assign a2_val = a_val_reg[2];  assign a3_val = a_val_reg[3];
  assign b0_val = b_val_reg[0];  assign b1_val = b_val_reg[1];
  assign b2_val = b_val_reg[2];  assign b3_val = b_val_reg[3];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_a_reg[i] <= '0;
        lane_b_reg[i] <= '0;
        a_val_reg[i]  <= '0;
        b_val_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accept && (wr_idx == 2'(i))) begin
          lane_a_reg[i] <= in_a;
          lane_b_reg[i] <= in_b;
        end
        if (issue) begin
          a_val_reg[i] <= gather_mask[i] ? lane_a_reg[i] : '0;
          b_val_reg[i] <= gather_mask[i] ? lane_b_reg[i] : '0;
        end
      end
    end
  end

  simd_grp_fifo u_fifo (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .push     (fl2_vld_reg),
    .push_grp (push_grp),
    .pop      (pop),
    .head_grp (head_grp),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Lowest not-yet-emitted lane of the head group is the current output.
  assign remaining  = head_grp.mask & ~done_reg;
  assign cur_onehot = remaining & (~remaining + LANES'(1));

  always_comb begin
    cur_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (remaining[i]) cur_idx = 2'(i);
    end
  end

  assign out_valid = !fifo_empty;
  assign out_sum   = out_valid ? head_grp.sum[cur_idx] : '0;
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && ((remaining & ~cur_onehot) == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      count_reg    <= '0;
      timer_reg    <= '0;
      credit_reg   <= '0;
      fl1_vld_reg  <= 1'b0;
      fl2_vld_reg  <= 1'b0;
      fl1_mask_reg <= '0;
      fl2_mask_reg <= '0;
      done_reg     <= '0;
    end else begin
      if (issue)       count_reg <= accept ? 3'd1 : 3'd0;
      else if (accept) count_reg <= count_reg + 3'd1;

      if (accept || issue)
        timer_reg <= '0;
      else if ((count_reg != 3'd0) && (count_reg < 3'd4) && (timer_reg < TIMER_MAX))
        timer_reg <= timer_reg + 8'd1;

      if (issue && !pop)      credit_reg <= credit_reg + 2'd1;
      else if (!issue && pop) credit_reg <= credit_reg - 2'd1;

      fl1_vld_reg  <= issue;
      fl1_mask_reg <= issue ? gather_mask : '0;
      fl2_vld_reg  <= fl1_vld_reg;
      fl2_mask_reg <= fl1_mask_reg;

      if (pop)            done_reg <= '0;
      else if (handshake) done_reg <= done_reg | cur_onehot;
    end
  end
endmodule

// File: tb/tb_simd_add4_gather.sv
// Directed bench for simd_add4_gather wired to the real four-lane SIMD adder.
module tb_simd_add4_gather;
  localparam int TIMEOUT = 16;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0, in_b = '0;
  logic        flush = 1'b0;
  logic [11:0] a0_val, a1_val, a2_val, a3_val, b0_val, b1_val, b2_val, b3_val;
  logic        simd_ce;
  logic [11:0] ap_return_0, ap_return_1, ap_return_2, ap_return_3;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic        busy;

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  simd_add4_gather #(.TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .flush(flush),
    .a0_val(a0_val), .a1_val(a1_val), .a2_val(a2_val), .a3_val(a3_val),
    .b0_val(b0_val), .b1_val(b1_val), .b2_val(b2_val), .b3_val(b3_val),
    .simd_ce(simd_ce),
    .ap_return_0(ap_return_0), .ap_return_1(ap_return_1),
    .ap_return_2(ap_return_2), .ap_return_3(ap_return_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  simd_add4 u_add (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(simd_ce),
    .a0_val(a0_val), .a1_val(a1_val), .a2_val(a2_val), .a3_val(a3_val),
    .b0_val(b0_val), .b1_val(b1_val), .b2_val(b2_val), .b3_val(b3_val),
    .ap_return_0(ap_return_0), .ap_return_1(ap_return_1),
    .ap_return_2(ap_return_2), .ap_return_3(ap_return_3)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] s;
  } vec_t;

  vec_t        tbl [10];
  logic [11:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          out_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: in-order scoreboard and hold-while-stalled check.
  initial begin
    logic        prev_stall;
    logic [11:0] prev_sum;
    prev_stall = 1'b0;
    prev_sum   = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) check("out_sum_hold", out_sum, prev_sum);
        if (out_valid && out_ready) begin
          out_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got sum %0d, expected no output (cycle %0d)", out_sum, cyc);
          end else begin
            check("out_sum", out_sum, exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] s,
                      output int acc_cyc);
    acc_cyc  = -1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int n = 0; n < 300; n++) begin
      @(negedge ap_clk);
      if (in_ready) begin
        acc_cyc = cyc;
        exp_q.push_back(s);
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    check("send_accepted", (acc_cyc >= 0) ? 1 : 0, 1);
  endtask

  task automatic wait_valid(output int c);
    c = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (out_valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge ap_clk);
      if (!busy) break;
    end
    check(name, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
    step();
  endtask

  initial begin
    int last, acc, c, snap, sent;
    logic [11:0] va [20];
    logic [11:0] vb [20];
    logic [11:0] vs [20];

    tbl[0] = '{12'd1,    12'd2,    12'd3};
    tbl[1] = '{12'd3,    12'd4,    12'd7};
    tbl[2] = '{12'd100,  12'd200,  12'd300};
    tbl[3] = '{12'd4095, 12'd1,    12'd0};
    tbl[4] = '{12'd10,   12'd5,    12'd15};
    tbl[5] = '{12'd2000, 12'd3000, 12'd904};
    tbl[6] = '{12'd4095, 12'd4095, 12'd4094};
    tbl[7] = '{12'd7,    12'd8,    12'd15};
    tbl[8] = '{12'd0,    12'd0,    12'd0};
    tbl[9] = '{12'd2048, 12'd2048, 12'd0};

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_simd_ce", simd_ce, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_a0_val", a0_val, 0);
    step();
    step();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_simd_ce", simd_ce, 1);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // Full group of four, back to back
    snap = out_seen;
    last = 0;
    for (int i = 0; i < 4; i++) send(tbl[i].a, tbl[i].b, tbl[i].s, last);
    wait_valid(c);
    check("t1_first_out_latency", c - last, 4);
    wait_idle("t1_idle");
    check("t1_count", out_seen - snap, 4);

    // Single request, timeout issue
    snap = out_seen;
    send(tbl[4].a, tbl[4].b, tbl[4].s, acc);
    wait_valid(c);
    check("t2_timeout_latency", c - acc, TIMEOUT + 3);
    check("t2_busy_before_hs", busy, 1);
    @(negedge ap_clk);
    check("t2_busy_after_hs", busy, 0);
    step();
    check("t2_count", out_seen - snap, 1);

    // Two requests, then a one-cycle flush
    snap = out_seen;
    send(tbl[5].a, tbl[5].b, tbl[5].s, acc);
    send(tbl[6].a, tbl[6].b, tbl[6].s, last);
    flush = 1'b1;
    c = cyc;
    step();
    flush = 1'b0;
    @(negedge ap_clk);
    check("t3_a0_val", a0_val, 2000);
    check("t3_b0_val", b0_val, 3000);
    check("t3_a1_val", a1_val, 4095);
    check("t3_b1_val", b1_val, 4095);
    check("t3_a2_val", a2_val, 0);
    check("t3_b2_val", b2_val, 0);
    check("t3_a3_val", a3_val, 0);
    check("t3_b3_val", b3_val, 0);
    check("t3_flush_cycle", c - last, 1);
    last = c;
    wait_valid(c);
    check("t3_out_latency", c - last, 3);
    wait_idle("t3_idle");
    check("t3_count", out_seen - snap, 2);

    // Back-pressure: credit fills, gather fills, then release
    snap = out_seen;
    for (int i = 0; i < 20; i++) begin
      va[i] = 12'(i * 257);
      vb[i] = 12'(3900 + i * 13);
      vs[i] = va[i] + vb[i];
    end
    out_ready = 1'b0;
    sent = 0;
    for (int k = 0; k < 40; k++) begin
      in_valid = (sent < 20);
      in_a = va[(sent < 20) ? sent : 0];
      in_b = vb[(sent < 20) ? sent : 0];
      @(negedge ap_clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(vs[sent]);
        sent++;
      end
      step();
    end
    in_a = va[(sent < 20) ? sent : 0];
    in_b = vb[(sent < 20) ? sent : 0];
    @(negedge ap_clk);
    check("t4_stall_accepted", sent, 16);
    check("t4_stall_in_ready", in_ready, 0);
    check("t4_stall_busy", busy, 1);
    check("t4_stall_out_valid", out_valid, 1);
    check("t4_no_out_while_stalled", out_seen - snap, 0);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sent < 20; k++) begin
      in_valid = 1'b1;
      in_a = va[sent];
      in_b = vb[sent];
      @(negedge ap_clk);
      if (in_ready) begin
        exp_q.push_back(vs[sent]);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    check("t4_total_accepted", sent, 20);
    wait_idle("t4_idle");
    check("t4_count", out_seen - snap, 20);

    // Reset pulsed two cycles after an issue
    for (int i = 6; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].s, last);
    step();
    step();
    ap_rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_simd_ce", simd_ce, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_out_sum", out_sum, 0);
    check("t5_rst_a0_val", a0_val, 0);
    check("t5_rst_b3_val", b3_val, 0);
    step();
    step();
    ap_rst = 1'b0;
    step();
    snap = out_seen;
    send(12'd7, 12'd8, 12'd15, acc);
    wait_valid(c);
    check("t5_lane0_timeout_latency", c - acc, TIMEOUT + 3);
    wait_idle("t5_idle");
    check("t5_count", out_seen - snap, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
